// File: rtl/mem_port_arbiter_if.sv
// Shared handshake bundle between the IF/MEM pipeline stages, the arbiter and the memory.
// The arbiter uses the slave modport; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_readmem;
  logic              dm_writemem;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_readmem, dm_writemem, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr, dm_readmem, dm_writemem, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and data stages; request-to-ack is 2 cycles plus wait states.
// Stalls are held while mem_ready is low; optional watchdog abort compiled in with MEM_ARB_WATCHDOG_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be within 1..255");
  end

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              d_req, i_req, grant_d, grant_i, timeout;

  // A requester is masked during its own ack cycle so a still-high level is not reissued.
  assign d_req   = (bus.dm_readmem | bus.dm_writemem) & ~dm_ack_q;
  assign i_req   = bus.if_req & ~if_ack_q;
  assign grant_d = d_req & ~(last_d_q & i_req);
  assign grant_i = i_req & ~grant_d;

`ifdef MEM_ARB_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       err_q, err_d;

  assign timeout = (state_q != IDLE) & ~bus.mem_ready & (wd_cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q | timeout;
    if (state_q == IDLE)     wd_cnt_d = 8'd0;
    else if (!bus.mem_ready) wd_cnt_d = wd_cnt_q + 8'd1;
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_d_d    = last_d_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_writemem;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          last_d_d    = 1'b1;
          state_d     = BUSY_D;
        end else if (grant_i) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          last_d_d   = 1'b0;
          state_d    = BUSY_I;
        end
      end
      BUSY_I: begin
        if (bus.mem_ready || timeout) begin
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_ready ? bus.mem_rdata : TIMEOUT_DATA;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready || timeout) begin
          mem_req_d = 1'b0;
          dm_ack_d  = 1'b1;
          if (!bus.mem_ready)  dm_rdata_d = TIMEOUT_DATA;
          else if (!mem_we_q)  dm_rdata_d = bus.mem_rdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      last_d_q    <= 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
      wd_cnt_q    <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      last_d_q    <= last_d_d;
`ifdef MEM_ARB_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = (bus.dm_readmem | bus.dm_writemem) & ~dm_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a wait-state memory responder.
// Random phase checks grants, data and stalls against transaction-level arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vec = 0;
  int miss = 0;

  // Memory responder: ready after wait_n stall cycles, unless hung.
  logic        hang = 1'b0, rand_wait = 1'b0, fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'h0;
  int          wait_n = 0, wcnt = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  always @(negedge clk) begin
    if (!bus.mem_req) begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
      if (rand_wait) wait_n = $urandom_range(0, 3);
    end else begin
      bus.mem_ready = !hang && (wcnt >= wait_n);
      wcnt++;
    end
    bus.mem_rdata = fixed_en ? fixed_val : memfn(bus.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_if_ack"}, bus.if_ack, 0);
    chk({tag, "_dm_ack"}, bus.dm_ack, 0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 0);
    chk({tag, "_dm_rdata"}, bus.dm_rdata, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_stall_if"}, bus.stall_if, 0);
    chk({tag, "_stall_mem"}, bus.stall_mem, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  logic        pi, pd, dwr, prev_d, prev_mreq, pend_i, pend_d, exp_d;
  logic [31:0] ia, da, dw, r;
  logic [31:0] gq[$];
  int          n, acks, age_i, age_d, max_i, max_d;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_readmem = 1'b0; bus.dm_writemem = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");

    // Reset while a data read is outstanding, then a fetch on a zero-wait memory.
    rst_n = 1'b1; hang = 1'b1;
    bus.dm_readmem = 1'b1; bus.dm_addr = 32'h8000_0010;
    tick();
    chk("rstm_grant_req", bus.mem_req, 1);
    chk("rstm_grant_addr", bus.mem_addr, 32'h8000_0010);
    repeat (2) tick();
    chk("rstm_still_busy", bus.mem_req, 1);
    #2 rst_n = 1'b0; bus.dm_readmem = 1'b0;
    #1 check_all_zero("rst_mid");
    hang = 1'b0; wait_n = 0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("fetch_req", bus.mem_req, 1);
    chk("fetch_ack_early", bus.if_ack, 0);
    chk("fetch_stall_if", bus.stall_if, 1);
    tick();
    chk("fetch_ack", bus.if_ack, 1);
    chk("fetch_rdata", bus.if_rdata, memfn(32'h0000_0040));
    chk("fetch_stall_if_off", bus.stall_if, 0);
    bus.if_req = 1'b0;
    tick();
    chk("fetch_ack_pulse", bus.if_ack, 0);

    // Contention: data write beats fetch, fetch follows right after the write ack.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0044;
    bus.dm_writemem = 1'b1; bus.dm_addr = 32'h8000_0200; bus.dm_wdata = 32'h1234_5678;
    tick();
    chk("cont_d_we", bus.mem_we, 1);
    chk("cont_d_addr", bus.mem_addr, 32'h8000_0200);
    chk("cont_d_wdata", bus.mem_wdata, 32'h1234_5678);
    chk("cont_stall_mem", bus.stall_mem, 1);
    tick();
    chk("cont_d_ack", bus.dm_ack, 1);
    chk("cont_no_reissue", bus.mem_req, 0);
    chk("cont_if_wait", bus.stall_if, 1);
    bus.dm_writemem = 1'b0;
    tick();
    chk("cont_i_req", bus.mem_req, 1);
    chk("cont_i_we", bus.mem_we, 0);
    chk("cont_i_addr", bus.mem_addr, 32'h0000_0044);
    tick();
    chk("cont_i_ack", bus.if_ack, 1);
    chk("cont_i_rdata", bus.if_rdata, memfn(32'h0000_0044));
    chk("cont_write_no_rdata", bus.dm_rdata, 0);
    bus.if_req = 1'b0;

    // Load with three wait states.
    fixed_en = 1'b1; fixed_val = 32'hCAFE_F00D; wait_n = 3;
    bus.dm_readmem = 1'b1; bus.dm_addr = 32'h0000_0100;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("load_req", bus.mem_req, 1);
      chk("load_addr", bus.mem_addr, 32'h0000_0100);
      chk("load_we", bus.mem_we, 0);
      chk("load_no_ack", bus.dm_ack, 0);
      chk("load_stall", bus.stall_mem, 1);
    end
    tick();
    chk("load_ack", bus.dm_ack, 1);
    chk("load_rdata", bus.dm_rdata, 32'hCAFE_F00D);
    chk("load_req_drop", bus.mem_req, 0);
    chk("load_stall_off", bus.stall_mem, 0);
    bus.dm_readmem = 1'b0; fixed_en = 1'b0; wait_n = 0;
    tick();
    chk("load_ack_pulse", bus.dm_ack, 0);
    chk("load_rdata_hold", bus.dm_rdata, 32'hCAFE_F00D);

    // Illegal read+write: write wins, dm_rdata untouched.
    bus.dm_readmem = 1'b1; bus.dm_writemem = 1'b1;
    bus.dm_addr = 32'h8000_0300; bus.dm_wdata = 32'hA5A5_5A5A;
    tick();
    chk("illegal_we", bus.mem_we, 1);
    chk("illegal_wdata", bus.mem_wdata, 32'hA5A5_5A5A);
    tick();
    chk("illegal_ack", bus.dm_ack, 1);
    chk("illegal_rdata_hold", bus.dm_rdata, 32'hCAFE_F00D);
    bus.dm_readmem = 1'b0; bus.dm_writemem = 1'b0;

    // Fairness: both held continuously alternate D, I, D, I.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0048;
    tick();
    chk("fair_pre_addr", bus.mem_addr, 32'h0000_0048);
    tick();
    chk("fair_pre_ack", bus.if_ack, 1);
    bus.if_addr = 32'h0000_004C;
    bus.dm_readmem = 1'b1; bus.dm_addr = 32'h8000_0400;
    prev_mreq = bus.mem_req;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.mem_req && !prev_mreq) gq.push_back(bus.mem_addr);
      prev_mreq = bus.mem_req;
    end
    chk("fair_count", 32'(gq.size() >= 4), 1);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      chk("fair_order", gq[k], (k % 2 == 0) ? 32'h8000_0400 : 32'h0000_004C);
    bus.if_req = 1'b0; bus.dm_readmem = 1'b0;
    repeat (4) tick();

    // Memory never answers.
    hang = 1'b1; bus.dm_readmem = 1'b1; bus.dm_addr = 32'h8000_0500;
`ifdef MEM_ARB_WATCHDOG_EN
    n = 0;
    while (!bus.dm_ack && n < 40) begin
      tick();
      n++;
    end
    chk("wd_latency", n, TO + 1);
    chk("wd_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
    chk("wd_err", bus.err, 1);
    chk("wd_req_drop", bus.mem_req, 0);
    bus.dm_readmem = 1'b0;
    repeat (3) tick();
    chk("wd_err_sticky", bus.err, 1);
`else
    acks = 0;
    repeat (100) begin
      tick();
      if (bus.dm_ack) acks++;
    end
    chk("nowd_req_held", bus.mem_req, 1);
    chk("nowd_err", bus.err, 0);
    chk("nowd_no_ack", acks, 0);
`endif
    #2 rst_n = 1'b0; bus.dm_readmem = 1'b0; hang = 1'b0;
    #1 check_all_zero("rst_after_wd");
    @(negedge clk) rst_n = 1'b1;

    // Randomized traffic against transaction-level arbitration rules.
    rand_wait = 1'b1;
    pi = 0; pd = 0; dwr = 0; prev_d = 0; prev_mreq = 0; pend_i = 0; pend_d = 0;
    ia = 0; da = 0; dw = 0; age_i = 0; age_d = 0; max_i = 0; max_d = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!prev_mreq) begin
        chk("rnd_grant", bus.mem_req, pend_i | pend_d);
        if (bus.mem_req) begin
          exp_d = pend_d & ~(prev_d & pend_i);
          chk("rnd_addr", bus.mem_addr, exp_d ? da : ia);
          chk("rnd_we", bus.mem_we, exp_d & dwr);
          if (exp_d & dwr) chk("rnd_wdata", bus.mem_wdata, dw);
          prev_d = exp_d;
        end
      end
      prev_mreq = bus.mem_req;
      chk("rnd_stall_if", bus.stall_if, pi & ~bus.if_ack);
      chk("rnd_stall_mem", bus.stall_mem, pd & ~bus.dm_ack);
      if (bus.if_ack) begin
        chk("rnd_if_owed", pi, 1);
        chk("rnd_if_rdata", bus.if_rdata, memfn(ia));
      end
      if (bus.dm_ack) begin
        chk("rnd_dm_owed", pd, 1);
        if (!dwr) chk("rnd_dm_rdata", bus.dm_rdata, memfn(da));
      end
      if (pi && !bus.if_ack) age_i++; else age_i = 0;
      if (pd && !bus.dm_ack) age_d++; else age_d = 0;
      if (age_i > max_i) max_i = age_i;
      if (age_d > max_d) max_d = age_d;
      if (bus.if_ack || !pi) begin
        pi = ($urandom_range(0, 2) != 0);
        r = $urandom(); ia = {1'b0, r[30:0]};
      end
      if (bus.dm_ack || !pd) begin
        pd = ($urandom_range(0, 2) != 0);
        r = $urandom(); da = {1'b1, r[30:0]};
        dw = $urandom(); dwr = 1'($urandom_range(0, 1));
      end
      bus.if_req = pi; bus.if_addr = ia;
      bus.dm_readmem = pd & ~dwr; bus.dm_writemem = pd & dwr;
      bus.dm_addr = da; bus.dm_wdata = dw;
      pend_i = pi & ~bus.if_ack;
      pend_d = pd & ~bus.dm_ack;
    end
    chk("rnd_fetch_latency_bound", 32'(max_i <= 30), 1);
    chk("rnd_data_latency_bound", 32'(max_d <= 30), 1);
    bus.if_req = 1'b0; bus.dm_readmem = 1'b0; bus.dm_writemem = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port, variable-latency memory between instruction fetch (IF) and the data-memory stage (MEM).
- The MEM side is driven by the decoded `readmem`/`writemem` controls.
- Serialises requests, holds the memory handshake, returns read data with a one-cycle acknowledge, and generates per-stage stall signals that freeze the pipeline while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, watchdog limit in cycles (used only with watchdog compiled in); legal range 1..255

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, level, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_rdata`  out  DATA_W  fetched word, valid when `if_ack`
- `if_ack`  out  1  one-cycle fetch completion pulse
- `dm_readmem`  in  1  data read request, level
- `dm_writemem`  in  1  data write request, level
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_rdata`  out  DATA_W  load data, valid when `dm_ack`
- `dm_ack`  out  1  one-cycle data completion pulse
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completion, sampled only while `mem_req`=1
- `stall_if`  out  1  `if_req & ~if_ack` (combinational)
- `stall_mem`  out  1  `(dm_readmem|dm_writemem) & ~dm_ack` (combinational)
- `err`  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset: state=IDLE; `mem_req`, `mem_we`, `if_ack`, `dm_ack`, `err` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0; `last_d` = 0.
- Effective requests in IDLE mask the request currently being acknowledged:
  - `d_req = (dm_readmem|dm_writemem) & ~dm_ack`
  - `i_req = if_req & ~if_ack`
- Grant in IDLE:
  - Data wins, unless `last_d`=1 and `i_req`=1; in that case fetch wins.
  - Granting data sets `last_d`=1; granting fetch clears it.
  - This prevents fetch starvation under back-to-back data accesses.
- On grant (registered, same edge):
  - Load `mem_addr`/`mem_wdata`.
  - `mem_we = dm_writemem`; forced 0 for fetch.
  - `mem_req`=1; go to BUSY_D or BUSY_I.
- `dm_readmem` and `dm_writemem` both high is illegal; write takes precedence.
- In BUSY_x with `mem_ready`=1 at an edge:
  - `mem_req`←0.
  - Matching `x_ack`←1 for exactly one cycle; read data captured into `x_rdata`.
  - State←IDLE.
- `if_rdata`/`dm_rdata` hold their last captured value until the next completion. Writes do not update `dm_rdata`.
- Request deassertion while BUSY is ignored: the transaction completes and the ack is still pulsed.

## Timing
- Grant edge: request high at edge E0 → `mem_req` high from E0.
- Memory with zero wait states (`mem_ready`=1 in the first `mem_req` cycle): `mem_req` and `mem_ready` seen at E1 → ack high in cycle E1..E2.
- Minimum request-to-ack latency is 2 cycles; each extra wait cycle adds 1.
- Back-to-back: a new grant can occur at the edge ending the ack cycle, giving 1 transaction per 2 cycles at best.
- Simultaneous `if_req` and `dm_*` from IDLE: data first, then fetch. Fetch ack arrives no earlier than 4 cycles after the requests.
- Reset mid-transaction: immediate return to reset values; the memory transaction is abandoned without an ack.

## Configuration
- `MEM_ARB_WATCHDOG_EN` defined:
  - An 8-bit counter clears on grant and increments each BUSY cycle with `mem_ready`=0.
  - When the count reaches `TIMEOUT`: `mem_req`←0, matching ack pulsed, `x_rdata`←`DATA_W'hDEADBEEF`, `err`←1 (sticky until reset), state←IDLE.
- `MEM_ARB_WATCHDOG_EN` undefined: no counter; BUSY waits indefinitely; `err` tied 0.

## Test plan
- Reset: assert `rst_n`=0 mid-BUSY_D → all outputs 0 at once; after release with `if_req`=1 and `mem_ready`=1 tied high → `if_ack` at cycle 2, `if_rdata`=`mem_rdata`.
- Load with 3 wait states: `dm_readmem`=1, `dm_addr`=0x100, `mem_rdata`=0xCAFEF00D → `mem_req` high 4 cycles with `mem_addr`=0x100, `mem_we`=0; `dm_ack` at cycle 5 with `dm_rdata`=0xCAFEF00D; `stall_mem` high until the ack.
- Contention: `if_req` and `dm_writemem` rise together, `mem_ready`=1 → data write granted first (`mem_we`=1, `mem_wdata`=`dm_wdata`), then fetch; no request reissued during its ack cycle.
- Fairness: `dm_readmem` held continuously alongside `if_req` → grants alternate D, I, D, I.
- Illegal combination: `dm_readmem`=`dm_writemem`=1 → `mem_we`=1.
- Watchdog (macro on, `TIMEOUT`=15): `mem_ready`=0 → `dm_ack` at 15 BUSY cycles, `dm_rdata`=0xDEADBEEF, `err`=1 sticky. Macro off: `mem_req` still high after 100 cycles, `err`=0.
